// File: rtl/mm_spi_host.sv
// SPI mode-0 master framing one accelerator transaction: TX_BYTES operand bytes out,
// wait for the ready flag (bounded by TIMEOUT), then RX_BYTES result bytes in.
module mm_spi_host #(
   parameter int CLK_DIV  = 4,
   parameter int TX_BYTES = 8,
   parameter int RX_BYTES = 8,
   parameter int TIMEOUT  = 4096
) (
   input  logic       hz100,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       spi_clk,
   output logic       cs,
   output logic       mosi,
   input  logic       miso,
   input  logic       ready
);

   localparam int MAX_BYTES = (TX_BYTES > RX_BYTES) ? TX_BYTES : RX_BYTES;
   localparam int BYTE_W    = $clog2(MAX_BYTES + 1);
   localparam int DIV_W     = $clog2(CLK_DIV);
   localparam int TMO_W     = $clog2(TIMEOUT + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
   localparam logic [BYTE_W-1:0] TX_N     = BYTE_W'(TX_BYTES);
   localparam logic [BYTE_W-1:0] RX_N     = BYTE_W'(RX_BYTES);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      TX_SHIFT,
      WAIT_RDY,
      RX_SHIFT,
      FINISH
   } state_t;

   state_t             state_reg, state_next;
   logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
   logic [2:0]         bit_cnt_reg, bit_cnt_next;
   logic [BYTE_W-1:0]  byte_cnt_reg, byte_cnt_next;
   logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
   logic [7:0]         tx_sh_reg, tx_sh_next;
   logic [6:0]         rx_sh_reg, rx_sh_next;
   logic [7:0]         rx_data_reg, rx_data_next;
   logic               rx_valid_reg, rx_valid_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;
   logic               err_reg, err_next;
   logic               spi_clk_reg, spi_clk_next;
   logic               cs_reg, cs_next;

   logic               miso_meta_reg, miso_sync_reg;
   logic               ready_meta_reg, ready_sync_reg;

   logic               phase_end;
   logic [DIV_W-1:0]   div_inc;
   logic [BYTE_W-1:0]  byte_inc;
   logic [TMO_W-1:0]   tmo_inc;
   logic [7:0]         rx_sample;

   always_ff @(posedge hz100) begin
      if (reset) begin
         miso_meta_reg  <= 1'b0;
         miso_sync_reg  <= 1'b0;
         ready_meta_reg <= 1'b0;
         ready_sync_reg <= 1'b0;
      end else begin
         miso_meta_reg  <= miso;
         miso_sync_reg  <= miso_meta_reg;
         ready_meta_reg <= ready;
         ready_sync_reg <= ready_meta_reg;
      end
   end

   always_ff @(posedge hz100) begin
      if (reset) begin
         state_reg    <= IDLE;
         div_cnt_reg  <= '0;
         bit_cnt_reg  <= '0;
         byte_cnt_reg <= '0;
         tmo_cnt_reg  <= '0;
         tx_sh_reg    <= '0;
         rx_sh_reg    <= '0;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         spi_clk_reg  <= 1'b0;
         cs_reg       <= 1'b1;
      end else begin
         state_reg    <= state_next;
         div_cnt_reg  <= div_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         byte_cnt_reg <= byte_cnt_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         tx_sh_reg    <= tx_sh_next;
         rx_sh_reg    <= rx_sh_next;
         rx_data_reg  <= rx_data_next;
         rx_valid_reg <= rx_valid_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         spi_clk_reg  <= spi_clk_next;
         cs_reg       <= cs_next;
      end
   end

   assign phase_end = (div_cnt_reg == DIV_LAST);
   assign div_inc   = div_cnt_reg + DIV_W'(1);
   assign byte_inc  = byte_cnt_reg + BYTE_W'(1);
   assign tmo_inc   = tmo_cnt_reg + TMO_W'(1);
   assign rx_sample = {rx_sh_reg, miso_sync_reg};

   always_comb begin
      state_next    = state_reg;
      div_cnt_next  = div_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      byte_cnt_next = byte_cnt_reg;
      tmo_cnt_next  = tmo_cnt_reg;
      tx_sh_next    = tx_sh_reg;
      rx_sh_next    = rx_sh_reg;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      err_next      = err_reg;
      spi_clk_next  = spi_clk_reg;
      cs_next       = cs_reg;

      case (state_reg)
         IDLE: begin
            spi_clk_next = 1'b0;
            if (start) begin
               state_next    = LOAD;
               busy_next     = 1'b1;
               cs_next       = 1'b0;
               err_next      = 1'b0;
               byte_cnt_next = '0;
               tx_sh_next    = '0;
            end
         end

         // The LOAD cycle counts as the first cycle of the next bit's low phase,
         // so back-to-back bytes keep an uninterrupted 2*CLK_DIV bit period.
         LOAD: begin
            spi_clk_next = 1'b0;
            if (tx_valid) begin
               tx_sh_next   = tx_data;
               bit_cnt_next = '0;
               div_cnt_next = DIV_ONE;
               state_next   = TX_SHIFT;
            end
         end

         TX_SHIFT: begin
            if (!phase_end) begin
               div_cnt_next = div_inc;
            end else begin
               div_cnt_next = '0;
               if (!spi_clk_reg) begin
                  spi_clk_next = 1'b1;
               end else begin
                  spi_clk_next = 1'b0;
                  if (bit_cnt_reg == 3'd7) begin
                     bit_cnt_next  = '0;
                     byte_cnt_next = byte_inc;
                     if (byte_inc < TX_N) begin
                        state_next = LOAD;
                     end else begin
                        state_next   = WAIT_RDY;
                        tx_sh_next   = '0;
                        tmo_cnt_next = '0;
                     end
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 3'd1;
                     tx_sh_next   = {tx_sh_reg[6:0], 1'b0};
                  end
               end
            end
         end

         WAIT_RDY: begin
            spi_clk_next = 1'b0;
            if (ready_sync_reg) begin
               state_next    = RX_SHIFT;
               div_cnt_next  = '0;
               bit_cnt_next  = '0;
               byte_cnt_next = '0;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               state_next = IDLE;
               cs_next    = 1'b1;
               err_next   = 1'b1;
               done_next  = 1'b1;
               busy_next  = 1'b0;
            end else begin
               tmo_cnt_next = tmo_inc;
            end
         end

         // miso is captured on the last cycle of each high phase
         RX_SHIFT: begin
            if (!phase_end) begin
               div_cnt_next = div_inc;
            end else begin
               div_cnt_next = '0;
               if (!spi_clk_reg) begin
                  spi_clk_next = 1'b1;
               end else begin
                  spi_clk_next = 1'b0;
                  rx_sh_next   = rx_sample[6:0];
                  if (bit_cnt_reg == 3'd7) begin
                     rx_data_next  = rx_sample;
                     rx_valid_next = 1'b1;
                     bit_cnt_next  = '0;
                     byte_cnt_next = byte_inc;
                     if (!(byte_inc < RX_N)) begin
                        state_next = FINISH;
                        cs_next    = 1'b1;
                     end
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 3'd1;
                  end
               end
            end
         end

         FINISH: begin
            spi_clk_next = 1'b0;
            if (phase_end) begin
               div_cnt_next = '0;
               state_next   = IDLE;
               done_next    = 1'b1;
               busy_next    = 1'b0;
            end else begin
               div_cnt_next = div_inc;
            end
         end

         default: begin
            state_next   = IDLE;
            cs_next      = 1'b1;
            spi_clk_next = 1'b0;
            busy_next    = 1'b0;
         end
      endcase
   end

   assign tx_ready = (state_reg == LOAD);
   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign err      = err_reg;
   assign spi_clk  = spi_clk_reg;
   assign cs       = cs_reg;
   assign mosi     = tx_sh_reg[7];

endmodule

// File: tb/tb_mm_spi_host.sv
// Directed bench for mm_spi_host with a mode-0 slave model and byte scoreboards
// for the operand stream (mosi) and the result stream (rx_data).
module tb_mm_spi_host;

   localparam int CLK_DIV  = 4;
   localparam int TX_BYTES = 2;
   localparam int RX_BYTES = 1;
   localparam int TIMEOUT  = 64;

   logic       hz100 = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       done;
   logic       err;
   logic       spi_clk;
   logic       cs;
   logic       mosi;
   logic       miso = 1'b0;
   logic       ready = 1'b0;

   mm_spi_host #(
      .CLK_DIV (CLK_DIV),
      .TX_BYTES(TX_BYTES),
      .RX_BYTES(RX_BYTES),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .hz100   (hz100),
      .reset   (reset),
      .start   (start),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .spi_clk (spi_clk),
      .cs      (cs),
      .mosi    (mosi),
      .miso    (miso),
      .ready   (ready)
   );

   always #5 hz100 = ~hz100;

   int cyc = 0;
   always @(posedge hz100) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   logic [7:0] exp_tx_q[$];
   logic [7:0] exp_rx_q[$];

   // slave model state
   int         edge_cnt = 0;
   int         txn_edges = -1;
   int         bad_gap = 0;
   int         gap9 = 0;
   int         gap17 = 0;
   int         last_rise = 0;
   int         first_rise = 0;
   int         rdy_delay = -1;
   int         rdy_cnt = -1;
   logic       pre_rdy = 1'b0;
   logic [7:0] slv_sh = 8'h00;
   logic [7:0] slv_resp = 8'h00;
   logic       prev_sclk = 1'b0;
   logic       prev_cs = 1'b1;
   logic [7:0] slv_exp;

   // monitor state
   int         rx_pulses = 0;
   int         done_pulses = 0;
   int         done_cyc = 0;
   logic [7:0] mon_exp;

   // bench state
   int         last_hs = 0;
   int         hs_first = 0;
   int         stall_viol = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Mode-0 slave: captures mosi on rising spi_clk, shifts miso after falling spi_clk.
   always @(negedge hz100) begin
      if (cs === 1'b1) begin
         if (prev_cs === 1'b0) begin
            txn_edges = edge_cnt;
            miso = 1'b0;
            rdy_cnt = -1;
         end
         edge_cnt = 0;
         ready = pre_rdy;
      end else begin
         if (spi_clk === 1'b1 && prev_sclk === 1'b0) begin
            edge_cnt++;
            if (edge_cnt == 1) first_rise = cyc;
            else if (edge_cnt == 9) gap9 = cyc - last_rise;
            else if (edge_cnt == 17) gap17 = cyc - last_rise;
            else if (edge_cnt <= 16 && (cyc - last_rise) != 2 * CLK_DIV) bad_gap++;
            last_rise = cyc;
            if (edge_cnt <= 16) begin
               slv_sh = {slv_sh[6:0], mosi};
               if (edge_cnt == 8 || edge_cnt == 16) begin
                  if (exp_tx_q.size() == 0) begin
                     chk("tx_unexpected", 32'(slv_sh), 32'hFFFF_FFFF);
                  end else begin
                     slv_exp = exp_tx_q.pop_front();
                     chk("tx_byte", 32'(slv_sh), 32'(slv_exp));
                  end
               end
            end
         end
         if (spi_clk === 1'b0 && prev_sclk === 1'b1) begin
            if (edge_cnt >= 16 && edge_cnt < 24) miso = slv_resp[3'(23 - edge_cnt)];
            if (edge_cnt == 16 && rdy_delay > 0) rdy_cnt = rdy_delay;
         end
         if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) ready = 1'b1;
         end
         if (pre_rdy) ready = 1'b1;
      end
      prev_sclk = spi_clk;
      prev_cs = cs;
   end

   always @(negedge hz100) begin
      if (rx_valid === 1'b1) begin
         rx_pulses++;
         if (exp_rx_q.size() == 0) begin
            chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
         end else begin
            mon_exp = exp_rx_q.pop_front();
            chk("rx_data", 32'(rx_data), 32'(mon_exp));
         end
      end
      if (done === 1'b1) begin
         done_pulses++;
         done_cyc = cyc;
      end
   end

   task automatic push_byte(input logic [7:0] b);
      int n = 0;
      tx_data = b;
      tx_valid = 1'b1;
      exp_tx_q.push_back(b);
      while (tx_ready !== 1'b1 && n < 500) begin
         @(negedge hz100);
         n++;
      end
      if (n >= 500) chk("tx_handshake", 32'(tx_ready), 32'd1);
      last_hs = cyc;
      @(negedge hz100);
      tx_valid = 1'b0;
   endtask

   task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] resp,
                          input int dly, input int stall, input bit want_rx, input bit extra_start);
      int n;
      rx_pulses = 0;
      done_pulses = 0;
      bad_gap = 0;
      gap9 = 0;
      gap17 = 0;
      stall_viol = 0;
      txn_edges = -1;
      slv_resp = resp;
      rdy_delay = dly;
      if (want_rx) exp_rx_q.push_back(resp);
      start = 1'b1;
      @(negedge hz100);
      start = 1'b0;
      chk("start_state", 32'({busy, cs, err}), 32'(3'b100));
      push_byte(b0);
      hs_first = last_hs;
      if (extra_start) begin
         start = 1'b1;
         @(negedge hz100);
         start = 1'b0;
      end
      if (stall > 0) begin
         n = 0;
         while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge hz100);
            n++;
         end
         repeat (stall) begin
            @(negedge hz100);
            if (spi_clk !== 1'b0 || cs !== 1'b0 || tx_ready !== 1'b1) stall_viol++;
         end
      end
      push_byte(b1);
      n = 0;
      while (done_pulses == 0 && n < 1500) begin
         @(negedge hz100);
         n++;
      end
      if (n >= 1500) chk("done_wait", 32'(done_pulses), 32'd1);
      repeat (2) @(negedge hz100);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=hang expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset = 1'b1;
      repeat (3) @(negedge hz100);
      chk("rst_outs", 32'({spi_clk, cs, mosi, tx_ready, rx_valid, busy, done, err}), 32'(8'b0100_0000));
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      reset = 1'b0;
      @(negedge hz100);

      // 1: basic transaction
      run_txn(8'hA5, 8'h3C, 8'h96, 20, 0, 1'b1, 1'b0);
      chk("s1_first_edge", 32'(first_rise - hs_first), 32'(CLK_DIV));
      chk("s1_gap9", 32'(gap9), 32'(2 * CLK_DIV));
      chk("s1_bad_gap", 32'(bad_gap), 32'd0);
      chk("s1_edges", 32'(txn_edges), 32'd24);
      chk("s1_rx_pulses", 32'(rx_pulses), 32'd1);
      chk("s1_done_pulses", 32'(done_pulses), 32'd1);
      chk("s1_end", 32'({cs, err, busy, spi_clk}), 32'(4'b1000));
      chk("s1_rx_hold", 32'(rx_data), 32'h96);
      chk("s1_queues", 32'(exp_tx_q.size() + exp_rx_q.size()), 32'd0);

      // 2: ready never rises
      run_txn(8'h11, 8'h22, 8'h00, -1, 0, 1'b0, 1'b0);
      chk("s2_err", 32'(err), 32'd1);
      chk("s2_done_delay", 32'(done_cyc - last_rise), 32'(TIMEOUT + CLK_DIV));
      chk("s2_rx_pulses", 32'(rx_pulses), 32'd0);
      chk("s2_done_pulses", 32'(done_pulses), 32'd1);
      chk("s2_edges", 32'(txn_edges), 32'd16);
      repeat (10) @(negedge hz100);
      chk("s2_err_held", 32'({err, cs, busy}), 32'(3'b110));

      // 3: tx_valid withheld between bytes (start also clears err)
      run_txn(8'hC3, 8'h7E, 8'h0F, 5, 50, 1'b1, 1'b0);
      chk("s3_stall_viol", 32'(stall_viol), 32'd0);
      chk("s3_gap9", 32'(gap9), 32'(2 * CLK_DIV + 50));
      chk("s3_bad_gap", 32'(bad_gap), 32'd0);
      chk("s3_edges", 32'(txn_edges), 32'd24);
      chk("s3_rx_pulses", 32'(rx_pulses), 32'd1);
      chk("s3_queues", 32'(exp_tx_q.size() + exp_rx_q.size()), 32'd0);

      // 4: reset during TX bit 3, then a full transaction
      done_pulses = 0;
      rx_pulses = 0;
      start = 1'b1;
      @(negedge hz100);
      start = 1'b0;
      push_byte(8'hA5);
      n = 0;
      while (edge_cnt < 3 && n < 300) begin
         @(negedge hz100);
         n++;
      end
      if (n >= 300) chk("s4_edge_wait", 32'(edge_cnt), 32'd3);
      repeat (5) @(negedge hz100);
      reset = 1'b1;
      @(negedge hz100);
      chk("s4_rst_outs", 32'({cs, spi_clk, busy, tx_ready, mosi, rx_valid, done}), 32'(7'b1000000));
      reset = 1'b0;
      exp_tx_q.delete();
      @(negedge hz100);
      chk("s4_no_done", 32'(done_pulses + rx_pulses), 32'd0);
      run_txn(8'hA5, 8'h3C, 8'h96, 20, 0, 1'b1, 1'b0);
      chk("s4_edges", 32'(txn_edges), 32'd24);
      chk("s4_bad_gap", 32'(bad_gap), 32'd0);
      chk("s4_rx_pulses", 32'(rx_pulses), 32'd1);
      chk("s4_end", 32'({cs, err, busy, done_pulses[1:0]}), 32'(5'b10001));

      // 5: ready already high, extra start while busy
      pre_rdy = 1'b1;
      repeat (3) @(negedge hz100);
      run_txn(8'h5A, 8'hF0, 8'hE7, -1, 0, 1'b1, 1'b1);
      pre_rdy = 1'b0;
      chk("s5_gap17", 32'(gap17), 32'(2 * CLK_DIV + 1));
      chk("s5_edges", 32'(txn_edges), 32'd24);
      chk("s5_rx_pulses", 32'(rx_pulses), 32'd1);
      repeat (20) @(negedge hz100);
      chk("s5_done_pulses", 32'(done_pulses), 32'd1);
      chk("s5_idle", 32'({busy, cs, err}), 32'(3'b010));
      chk("s5_queues", 32'(exp_tx_q.size() + exp_rx_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
